// File: rtl/led_sequencer.sv
// led_sequencer: steps three LEDs through OFF / BLINK / CHASE / DIM display modes.
// A bouncing push button is synchronised and debounced on-chip, and each accepted
// press advances the mode. A prescaler sets the pattern rate and a free-running
// PWM counter dims the LEDs in DIM mode.
module led_sequencer #(
  parameter int TICK_DIV        = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PWM_BITS        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  output logic [1:0] mode,
  output logic       led1,
  output logic       led2,
  output logic       led3
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_DIM   = 2'd3
  } mode_t;

  mode_t state;
  mode_t state_next;

  logic                sync1;
  logic                sync2;
  logic                deb_level;
  logic                deb_level_d;
  logic [DEB_W-1:0]    deb_cnt;
  logic                press;

  logic [PRE_W-1:0]    pre_cnt;
  logic                tick;

  logic                phase;
  logic [1:0]          idx;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic [2:0]          led_next;
  logic [2:0]          led_q;

  // Two-flop synchroniser bringing the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // Accept a new button level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive samples; any return to the old level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_level   <= 1'b0;
      deb_level_d <= 1'b0;
      deb_cnt     <= '0;
    end else begin
      deb_level_d <= deb_level;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign press = deb_level & ~deb_level_d;
  assign tick  = (pre_cnt == PRE_LAST);

  // Pattern-rate prescaler; restarts on a press so the new mode gets a full first period.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (press || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MODE_OFF;
    end else begin
      state <= state_next;
    end
  end

  // Next mode: each accepted press steps OFF -> BLINK -> CHASE -> DIM -> OFF.
  always_comb begin
    state_next = state;
    if (press) begin
      case (state)
        MODE_OFF:   state_next = MODE_BLINK;
        MODE_BLINK: state_next = MODE_CHASE;
        MODE_CHASE: state_next = MODE_DIM;
        MODE_DIM:   state_next = MODE_OFF;
        default:    state_next = MODE_OFF;
      endcase
    end
  end

  // Per-mode pattern state, cleared on a press (which also swallows a coincident tick)
  // and otherwise advanced once per tick for the active mode only.
  always_ff @(posedge clk) begin
    if (rst || press) begin
      phase <= 1'b0;
      idx   <= 2'd0;
      duty  <= '0;
    end else if (tick) begin
      case (state)
        MODE_BLINK: phase <= ~phase;
        MODE_CHASE: idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        MODE_DIM:   duty  <= duty + PWM_BITS'(1);
        default:    ;
      endcase
    end
  end

  // Free-running PWM ramp shared by all modes; deliberately untouched by mode changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Decode the LED pattern {led3, led2, led1} from the current mode and pattern state.
  always_comb begin
    led_next = 3'b000;
    case (state)
      MODE_BLINK: led_next = {3{phase}};
      MODE_CHASE: begin
        case (idx)
          2'd0:    led_next = 3'b001;
          2'd1:    led_next = 3'b010;
          2'd2:    led_next = 3'b100;
          default: led_next = 3'b000;
        endcase
      end
      MODE_DIM:   led_next = {3{(pwm_cnt < duty)}};
      default:    led_next = 3'b000;
    endcase
  end

  // Register the LED drive so the pins are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= 3'b000;
    end else begin
      led_q <= led_next;
    end
  end

  assign mode = state;
  assign led1 = led_q[0];
  assign led2 = led_q[1];
  assign led3 = led_q[2];

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed, table-driven bench for led_sequencer with small
// parameters, plus hand-written sequences for bounce, DIM ramp and mid-pattern reset.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [1:0] mode;
  logic       led1;
  logic       led2;
  logic       led3;
  logic [2:0] leds;

  int checks = 0;
  int fails  = 0;
  int edges  = 0;

  typedef struct {
    logic       rst;
    logic       btn;
    logic       chk_leds;
    logic [1:0] mode;
    logic [2:0] leds;
  } vec_t;

  vec_t vecs[$];

  led_sequencer #(
    .TICK_DIV       (4),
    .DEBOUNCE_CYCLES(3),
    .PWM_BITS       (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .button(button),
    .mode  (mode),
    .led1  (led1),
    .led2  (led2),
    .led3  (led3)
  );

  assign leds = {led3, led2, led1};

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Drive inputs, advance one rising edge, then settle before sampling.
  task automatic applyStimulus(input logic r, input logic b);
    rst    = r;
    button = b;
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0);
    edges = 0;
  endtask

  task automatic addRun(input int n, input logic r, input logic b, input logic c,
                        input logic [1:0] m, input logic [2:0] l);
    vec_t v;
    v.rst = r; v.btn = b; v.chk_leds = c; v.mode = m; v.leds = l;
    repeat (n) vecs.push_back(v);
  endtask

  // Expected {led3,led2,led1} after edge t of the three-press sequence
  // (presses rise before edges 1, 17, 33; modes change at edges 6, 22, 38).
  function automatic int expLeds(input int t);
    int d;
    if (t <= 6) return 0;
    if (t <= 22) return (((t - 7) / 4) % 2) != 0 ? 7 : 0;
    if (t <= 38) return 1 << (((t - 23) / 4) % 3);
    d = ((t - 1 - 38) / 4) % 8;
    return (((t - 1) % 8) < d) ? 7 : 0;
  endfunction

  function automatic int expMode(input int t);
    if (t < 6)  return 0;
    if (t < 22) return 1;
    if (t < 38) return 2;
    return 3;
  endfunction

  initial begin
    rst    = 1'b1;
    button = 1'b0;

    // Reset, idle, then press/release cycles walking through all four modes.
    addRun(2,  1, 0, 1, 2'd0, 3'b000);
    addRun(50, 0, 0, 1, 2'd0, 3'b000);
    addRun(5,  0, 1, 1, 2'd0, 3'b000);
    addRun(5,  0, 1, 1, 2'd1, 3'b000);
    addRun(4,  0, 1, 1, 2'd1, 3'b111);
    addRun(4,  0, 1, 1, 2'd1, 3'b000);
    addRun(4,  0, 1, 1, 2'd1, 3'b111);
    addRun(4,  0, 0, 1, 2'd1, 3'b000);
    addRun(4,  0, 0, 1, 2'd1, 3'b111);
    addRun(4,  0, 1, 1, 2'd1, 3'b000);
    addRun(1,  0, 1, 1, 2'd1, 3'b111);
    addRun(1,  0, 1, 1, 2'd2, 3'b111);
    addRun(4,  0, 1, 1, 2'd2, 3'b001);
    addRun(4,  0, 0, 1, 2'd2, 3'b010);
    addRun(4,  0, 0, 1, 2'd2, 3'b100);
    addRun(4,  0, 0, 1, 2'd2, 3'b001);
    addRun(4,  0, 1, 1, 2'd2, 3'b010);
    addRun(1,  0, 1, 1, 2'd2, 3'b100);
    addRun(1,  0, 1, 1, 2'd3, 3'b100);
    addRun(4,  0, 1, 1, 2'd3, 3'b000);
    addRun(8,  0, 0, 0, 2'd3, 3'b000);
    addRun(5,  0, 1, 0, 2'd3, 3'b000);
    addRun(1,  0, 1, 0, 2'd0, 3'b000);
    addRun(4,  0, 1, 1, 2'd0, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].btn);
      checkOutput($sformatf("tbl%0d mode", i), mode, vecs[i].mode);
      if (vecs[i].chk_leds)
        checkOutput($sformatf("tbl%0d leds", i), leds, vecs[i].leds);
    end

    // Bounce: 1 for 2 cycles, 0 for 2 cycles, five times, then steady 1 -> one press only.
    $display("[TB] bounce sequence");
    doReset(2);
    for (int t = 1; t <= 45; t++) begin
      applyStimulus(1'b0, (t > 20) || (((t - 1) % 4) < 2));
      checkOutput($sformatf("bounce t%0d mode", t), mode, (t < 26) ? 0 : 1);
      if (t <= 26)
        checkOutput($sformatf("bounce t%0d leds", t), leds, 0);
    end

    // Three clean presses: BLINK, CHASE, then DIM entered on a prescaler tick,
    // followed by a full DIM ramp through duty 0..7 and back to 0.
    $display("[TB] three-press and DIM sequence");
    doReset(2);
    for (int t = 1; t <= 78; t++) begin
      applyStimulus(1'b0, (t <= 48) && (((t - 1) % 16) < 8));
      checkOutput($sformatf("seq t%0d mode", t), mode, expMode(t));
      checkOutput($sformatf("seq t%0d leds", t), leds, expLeds(t));
    end

    // Reset in the middle of BLINK with the button still held.
    $display("[TB] mid-pattern reset sequence");
    doReset(2);
    for (int t = 1; t <= 12; t++) applyStimulus(1'b0, 1'b1);
    checkOutput("preRst mode", mode, 1);
    checkOutput("preRst leds", leds, 7);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midRst mode", mode, 0);
    checkOutput("midRst leds", leds, 0);
    edges = 0;
    for (int t = 1; t <= 8; t++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput($sformatf("heldRst t%0d mode", t), mode, (t < 6) ? 0 : 1);
      checkOutput($sformatf("heldRst t%0d leds", t), leds, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
